// File: rtl/bp_c_mul1_if.sv
// Bundle of the shared linear-layer inputs, randomness and aligned outputs of bp_c_mul1.
// D is the number of shares; rnd carries one D(D-1)/2 slice per HPC2 gadget.
interface bp_c_mul1_if #(
    parameter int D = 2
);
    localparam int RW = 9 * D * (D - 1) / 2;

    logic          in_valid;
    logic [D-1:0]  t1, t2, t3, t4, t6, t8, t9, t10, t13, t14, t15;
    logic [D-1:0]  t16, t17, t19, t20, t22, t23, t24, t25, t26, t27, y5;
    logic [RW-1:0] rnd;

    logic          out_valid;
    logic [D-1:0]  m20, m21, m22, m23;
    logic [D-1:0]  t1_d, t2_d, t3_d, t4_d, t6_d, t8_d, t9_d, t10_d, t13_d;
    logic [D-1:0]  t15_d, t16_d, t17_d, t19_d, t20_d, t22_d, t23_d, t27_d, y5_d;

    modport master (
        output in_valid, rnd,
        output t1, t2, t3, t4, t6, t8, t9, t10, t13, t14, t15,
        output t16, t17, t19, t20, t22, t23, t24, t25, t26, t27, y5,
        input  out_valid, m20, m21, m22, m23,
        input  t1_d, t2_d, t3_d, t4_d, t6_d, t8_d, t9_d, t10_d, t13_d,
        input  t15_d, t16_d, t17_d, t19_d, t20_d, t22_d, t23_d, t27_d, y5_d
    );

    modport slave (
        input  in_valid, rnd,
        input  t1, t2, t3, t4, t6, t8, t9, t10, t13, t14, t15,
        input  t16, t17, t19, t20, t22, t23, t24, t25, t26, t27, y5,
        output out_valid, m20, m21, m22, m23,
        output t1_d, t2_d, t3_d, t4_d, t6_d, t8_d, t9_d, t10_d, t13_d,
        output t15_d, t16_d, t17_d, t19_d, t20_d, t22_d, t23_d, t27_d, y5_d
    );
endinterface

// File: rtl/bp_c_mul1.sv
// First nonlinear stage of the masked Boyar-Peralta S-box: nine HPC2 ANDs feeding the m20..m23 XOR network.
// Optional macro BP_C_MUL1_OUTREG_EN adds an output register stage (latency 2 instead of 1).

module MSKand_hpc2 #(
    parameter int D = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_en,
    input  logic [D-1:0]             i_a,
    input  logic [D-1:0]             i_b,
    input  logic [D*(D-1)/2-1:0]     i_rnd,
    output logic [D-1:0]             o_c
);
    logic [D-1:0]          r_a;
    logic [D-1:0]          r_ab;
    logic [D-1:0][D-1:0]   w_cross;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a  <= '0;
            r_ab <= '0;
        end else if (i_en) begin
            r_a  <= i_a;
            r_ab <= i_a & i_b;
        end
    end

    for (genvar gi = 0; gi < D; gi++) begin : g_row
        for (genvar gj = 0; gj < D; gj++) begin : g_col
            if (gi != gj) begin : g_pair
                // r_ij is shared by the (i,j) and (j,i) terms so it cancels on recombination.
                localparam int P = (gi < gj) ? (gi * (2 * D - gi - 1) / 2 + (gj - gi - 1))
                                             : (gj * (2 * D - gj - 1) / 2 + (gi - gj - 1));
                logic r_u;
                logic r_v;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_u <= 1'b0;
                        r_v <= 1'b0;
                    end else if (i_en) begin
                        r_u <= ~i_a[gi] & i_rnd[P];
                        r_v <= i_b[gj] ^ i_rnd[P];
                    end
                end

                assign w_cross[gi][gj] = r_u ^ (r_a[gi] & r_v);
            end else begin : g_diag
                assign w_cross[gi][gj] = 1'b0;
            end
        end
        assign o_c[gi] = r_ab[gi] ^ (^w_cross[gi]);
    end
endmodule

module bp_c_mul1 #(
    parameter int D = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    bp_c_mul1_if.slave    bus
);
    localparam int PW = D * (D - 1) / 2;
    localparam int NG = 9;
    localparam int NP = 18;

    logic [NG-1:0][D-1:0] w_ga;
    logic [NG-1:0][D-1:0] w_gb;
    logic [NG-1:0][D-1:0] w_gm;

    // Gadget k order: M1, M2, M4, M6, M7, M9, M11, M12, M14.
    assign w_ga[0] = bus.t13;  assign w_gb[0] = bus.t6;
    assign w_ga[1] = bus.t23;  assign w_gb[1] = bus.t8;
    assign w_ga[2] = bus.t19;  assign w_gb[2] = bus.y5;
    assign w_ga[3] = bus.t3;   assign w_gb[3] = bus.t16;
    assign w_ga[4] = bus.t22;  assign w_gb[4] = bus.t9;
    assign w_ga[5] = bus.t20;  assign w_gb[5] = bus.t17;
    assign w_ga[6] = bus.t1;   assign w_gb[6] = bus.t15;
    assign w_ga[7] = bus.t4;   assign w_gb[7] = bus.t27;
    assign w_ga[8] = bus.t2;   assign w_gb[8] = bus.t10;

    for (genvar k = 0; k < NG; k++) begin : g_and
        MSKand_hpc2 #(.D(D)) u_and (
            .clk   (clk),
            .rst_n (rst_n),
            .i_en  (bus.in_valid),
            .i_a   (w_ga[k]),
            .i_b   (w_gb[k]),
            .i_rnd (bus.rnd[k*PW +: PW]),
            .o_c   (w_gm[k])
        );
    end

    logic [NP-1:0][D-1:0] w_passIn;
    logic [NP-1:0][D-1:0] r_pass;
    logic [D-1:0]         r_t14, r_t24, r_t25, r_t26;
    logic                 r_valid1;

    assign w_passIn = {bus.t1, bus.t2, bus.t3, bus.t4, bus.t6, bus.t8, bus.t9, bus.t10, bus.t13,
                       bus.t15, bus.t16, bus.t17, bus.t19, bus.t20, bus.t22, bus.t23, bus.t27, bus.y5};

    // Linear terms are held on idle cycles so no share toggles without a new sharing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid1 <= 1'b0;
            r_pass   <= '0;
            r_t14    <= '0;
            r_t24    <= '0;
            r_t25    <= '0;
            r_t26    <= '0;
        end else begin
            r_valid1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_pass <= w_passIn;
                r_t14  <= bus.t14;
                r_t24  <= bus.t24;
                r_t25  <= bus.t25;
                r_t26  <= bus.t26;
            end
        end
    end

    logic [D-1:0] w_M1, w_M2, w_M4, w_M6, w_M7, w_M9, w_M11, w_M12, w_M14;
    logic [D-1:0] w_M3, w_M5, w_M8, w_M10, w_M13, w_M15;
    logic [D-1:0] w_M16, w_M17, w_M18, w_M19;
    logic [D-1:0] w_m20, w_m21, w_m22, w_m23;

    assign {w_M1, w_M2, w_M4, w_M6, w_M7, w_M9, w_M11, w_M12, w_M14} =
           {w_gm[0], w_gm[1], w_gm[2], w_gm[3], w_gm[4], w_gm[5], w_gm[6], w_gm[7], w_gm[8]};

    assign w_M3  = r_t14 ^ w_M1;
    assign w_M5  = w_M4  ^ w_M1;
    assign w_M8  = r_t26 ^ w_M6;
    assign w_M10 = w_M9  ^ w_M6;
    assign w_M13 = w_M12 ^ w_M11;
    assign w_M15 = w_M14 ^ w_M11;
    assign w_M16 = w_M3  ^ w_M2;
    assign w_M17 = w_M5  ^ r_t24;
    assign w_M18 = w_M8  ^ w_M7;
    assign w_M19 = w_M10 ^ w_M15;
    assign w_m20 = w_M16 ^ w_M13;
    assign w_m21 = w_M17 ^ w_M15;
    assign w_m22 = w_M18 ^ w_M13;
    assign w_m23 = w_M19 ^ r_t25;

    logic [3:0][D-1:0]    w_mNet;
    logic [3:0][D-1:0]    w_mFin;
    logic [NP-1:0][D-1:0] w_passFin;
    logic                 w_outValid;

    assign w_mNet = {w_m20, w_m21, w_m22, w_m23};

`ifdef BP_C_MUL1_OUTREG_EN
    logic [3:0][D-1:0]    r_mOut;
    logic [NP-1:0][D-1:0] r_passOut;
    logic                 r_valid2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid2  <= 1'b0;
            r_mOut    <= '0;
            r_passOut <= '0;
        end else begin
            r_valid2 <= r_valid1;
            if (r_valid1) begin
                r_mOut    <= w_mNet;
                r_passOut <= r_pass;
            end
        end
    end

    assign w_outValid = r_valid2;
    assign w_mFin     = r_mOut;
    assign w_passFin  = r_passOut;
`else
    assign w_outValid = r_valid1;
    assign w_mFin     = w_mNet;
    assign w_passFin  = r_pass;
`endif

    // Gating by out_valid also zeroes everything immediately on an asynchronous reset.
    logic [3:0][D-1:0]    w_mOut;
    logic [NP-1:0][D-1:0] w_passOut;

    assign w_mOut    = w_mFin    & {(4*D){w_outValid}};
    assign w_passOut = w_passFin & {(NP*D){w_outValid}};

    assign bus.out_valid = w_outValid;
    assign {bus.m20, bus.m21, bus.m22, bus.m23} = w_mOut;
    assign {bus.t1_d, bus.t2_d, bus.t3_d, bus.t4_d, bus.t6_d, bus.t8_d, bus.t9_d, bus.t10_d, bus.t13_d,
            bus.t15_d, bus.t16_d, bus.t17_d, bus.t19_d, bus.t20_d, bus.t22_d, bus.t23_d, bus.t27_d,
            bus.y5_d} = w_passOut;
endmodule

// File: tb/tb_bp_c_mul1.sv
// Directed and random checks of bp_c_mul1 with D=2, comparing recombined outputs to a golden Boyar-Peralta model.
// Honours BP_C_MUL1_OUTREG_EN by expecting two cycles of latency instead of one.
module tb_bp_c_mul1;
    localparam int D = 2;
`ifdef BP_C_MUL1_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic t1, t2, t3, t4, t6, t8, t9, t10, t13, t14, t15;
        logic t16, t17, t19, t20, t22, t23, t24, t25, t26, t27, y5;
    } lin_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bp_c_mul1_if #(.D(D)) bus ();

    bp_c_mul1 #(.D(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int passCount = 0;
    int checkCount = 0;
    int highCount = 0;

    logic        curV;
    logic [3:0]  curM;
    logic [17:0] curP;
    logic        pipeV [LAT];
    logic [3:0]  pipeM [LAT];
    logic [17:0] pipeP [LAT];

    function automatic logic [3:0] modelM(input lin_t p);
        logic M1, M2, M4, M6, M7, M9, M11, M12, M14;
        logic M3, M5, M8, M10, M13, M15, M16, M17, M18, M19;
        M1 = p.t13 & p.t6;  M2 = p.t23 & p.t8;  M4 = p.t19 & p.y5;
        M6 = p.t3 & p.t16;  M7 = p.t22 & p.t9;  M9 = p.t20 & p.t17;
        M11 = p.t1 & p.t15; M12 = p.t4 & p.t27; M14 = p.t2 & p.t10;
        M3 = p.t14 ^ M1;  M5 = M4 ^ M1;   M8 = p.t26 ^ M6;
        M10 = M9 ^ M6;    M13 = M12 ^ M11; M15 = M14 ^ M11;
        M16 = M3 ^ M2;    M17 = M5 ^ p.t24; M18 = M8 ^ M7; M19 = M10 ^ M15;
        return {M16 ^ M13, M17 ^ M15, M18 ^ M13, M19 ^ p.t25};
    endfunction

    function automatic logic [17:0] modelP(input lin_t p);
        return {p.t1, p.t2, p.t3, p.t4, p.t6, p.t8, p.t9, p.t10, p.t13,
                p.t15, p.t16, p.t17, p.t19, p.t20, p.t22, p.t23, p.t27, p.y5};
    endfunction

    function automatic logic [3:0] obsM();
        return {^bus.m20, ^bus.m21, ^bus.m22, ^bus.m23};
    endfunction

    function automatic logic [17:0] obsP();
        return {^bus.t1_d, ^bus.t2_d, ^bus.t3_d, ^bus.t4_d, ^bus.t6_d, ^bus.t8_d, ^bus.t9_d,
                ^bus.t10_d, ^bus.t13_d, ^bus.t15_d, ^bus.t16_d, ^bus.t17_d, ^bus.t19_d,
                ^bus.t20_d, ^bus.t22_d, ^bus.t23_d, ^bus.t27_d, ^bus.y5_d};
    endfunction

    function automatic logic anyOutBit();
        return |{bus.m20, bus.m21, bus.m22, bus.m23, bus.t1_d, bus.t2_d, bus.t3_d, bus.t4_d,
                 bus.t6_d, bus.t8_d, bus.t9_d, bus.t10_d, bus.t13_d, bus.t15_d, bus.t16_d,
                 bus.t17_d, bus.t19_d, bus.t20_d, bus.t22_d, bus.t23_d, bus.t27_d, bus.y5_d};
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    // Fresh random masks and rnd for every sharing; expected values come from the unshared value.
    task automatic applyStimulus(input logic v, input lin_t p);
        lin_t s0, s1;
        s0 = lin_t'(22'($urandom));
        s1 = lin_t'(s0 ^ p);
        bus.in_valid = v;
        bus.rnd = 9'($urandom);
        bus.t1 = {s1.t1, s0.t1};     bus.t2 = {s1.t2, s0.t2};     bus.t3 = {s1.t3, s0.t3};
        bus.t4 = {s1.t4, s0.t4};     bus.t6 = {s1.t6, s0.t6};     bus.t8 = {s1.t8, s0.t8};
        bus.t9 = {s1.t9, s0.t9};     bus.t10 = {s1.t10, s0.t10};  bus.t13 = {s1.t13, s0.t13};
        bus.t14 = {s1.t14, s0.t14};  bus.t15 = {s1.t15, s0.t15};  bus.t16 = {s1.t16, s0.t16};
        bus.t17 = {s1.t17, s0.t17};  bus.t19 = {s1.t19, s0.t19};  bus.t20 = {s1.t20, s0.t20};
        bus.t22 = {s1.t22, s0.t22};  bus.t23 = {s1.t23, s0.t23};  bus.t24 = {s1.t24, s0.t24};
        bus.t25 = {s1.t25, s0.t25};  bus.t26 = {s1.t26, s0.t26};  bus.t27 = {s1.t27, s0.t27};
        bus.y5 = {s1.y5, s0.y5};
        curV = v;
        curM = modelM(p);
        curP = modelP(p);
    endtask

    task automatic clearModel();
        for (int i = 0; i < LAT; i++) begin
            pipeV[i] = 1'b0;
            pipeM[i] = '0;
            pipeP[i] = '0;
        end
    endtask

    task automatic clockEdge();
        @(posedge clk);
        for (int i = LAT - 1; i > 0; i--) begin
            pipeV[i] = pipeV[i-1];
            pipeM[i] = pipeM[i-1];
            pipeP[i] = pipeP[i-1];
        end
        pipeV[0] = rst_n & curV;
        pipeM[0] = curM;
        pipeP[0] = curP;
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkEq({tag, ".valid"}, 32'(bus.out_valid), 32'(pipeV[LAT-1]));
        if (pipeV[LAT-1]) begin
            checkEq({tag, ".m"}, 32'(obsM()), 32'(pipeM[LAT-1]));
            checkEq({tag, ".pass"}, 32'(obsP()), 32'(pipeP[LAT-1]));
        end else begin
            checkEq({tag, ".zero"}, 32'(anyOutBit()), 32'd0);
        end
    endtask

    // One isolated sharing, with the recombined result also held against hand-computed constants.
    task automatic runOne(input string tag, input lin_t p, input logic [3:0] expM, input logic [17:0] expP);
        applyStimulus(1'b1, p);
        for (int k = 0; k < LAT; k++) begin
            clockEdge();
            checkOutput(tag);
            if (k == 0) applyStimulus(1'b0, '0);
        end
        checkEq({tag, ".hvalid"}, 32'(bus.out_valid), 32'd1);
        checkEq({tag, ".hm"}, 32'(obsM()), 32'(expM));
        checkEq({tag, ".hpass"}, 32'(obsP()), 32'(expP));
        clockEdge();
        checkOutput({tag, ".idle"});
    endtask

    initial begin
        lin_t p;
        clearModel();
        applyStimulus(1'b1, '1);

        // Reset held with in_valid high: reset must win and nothing may appear.
        for (int i = 0; i < 3; i++) begin
            clockEdge();
            checkEq("rst.valid", 32'(bus.out_valid), 32'd0);
            checkEq("rst.zero", 32'(anyOutBit()), 32'd0);
        end
        applyStimulus(1'b0, '0);
        #2 rst_n = 1'b1;
        clockEdge();
        checkOutput("post_rst_idle");

        runOne("zeros", '0, 4'b0000, 18'h00000);
        runOne("ones", '1, 4'b1111, 18'h3FFFF);
        p = '0; p.t13 = 1'b1; p.t6 = 1'b1;
        runOne("t13_t6", p, 4'b1100, 18'h02200);
        p = '0; p.t19 = 1'b1; p.y5 = 1'b1;
        runOne("t19_y5", p, 4'b0100, 18'h00021);

        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, lin_t'(22'($urandom)));
            clockEdge();
            checkOutput("b2b");
            if (bus.out_valid) highCount++;
        end
        applyStimulus(1'b0, '0);
        for (int i = 0; i < LAT; i++) begin
            clockEdge();
            checkOutput("b2b_flush");
            if (bus.out_valid) highCount++;
        end
        checkEq("b2b.count", 32'(highCount), 32'd100);

        // Asynchronous reset while a sharing is in flight.
        applyStimulus(1'b1, '1);
        clockEdge();
        checkOutput("flight");
        applyStimulus(1'b0, '0);
        #1 rst_n = 1'b0;
        clearModel();
        #1;
        checkEq("midrst.valid", 32'(bus.out_valid), 32'd0);
        checkEq("midrst.zero", 32'(anyOutBit()), 32'd0);
        clockEdge();
        checkOutput("midrst_hold");
        #2 rst_n = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            clockEdge();
            checkOutput("midrst_drain");
        end
        p = '0; p.t19 = 1'b1; p.y5 = 1'b1;
        runOne("after_rst", p, 4'b0100, 18'h00021);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/bp_c_mul1.md
# bp_c_mul1

First nonlinear stage of the masked Boyar–Peralta S-box datapath. It sits directly downstream of the top linear layer and consumes its 22 shared signals (t1…t27, y5). It computes the nine masked products M1, M2, M4, M6, M7, M9, M11, M12 and M14 with HPC2 AND gadgets, XOR-reduces them into the four GF(2^4) inversion inputs m20…m23, and forwards the 18 linear-layer values needed later by the bottom nonlinear layer, delayed to stay cycle-aligned with the m outputs.

## Interface
- d, 2, number of shares (masking order d-1).
- clk  input  1  clock; all registers on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input sharings and rnd are valid this cycle.
- t1, t2, t3, t4, t6, t8, t9, t10, t13, t14, t15, t16, t17, t19, t20, t22, t23, t24, t25, t26, t27, y5  input  d each  shared linear-layer outputs.
- rnd  input  9·d(d-1)/2  fresh randomness.
  - Slice k, of width d(d-1)/2, feeds gadget k.
  - Gadget order k=0..8: M1, M2, M4, M6, M7, M9, M11, M12, M14.
- out_valid  output  1  outputs valid.
- m20, m21, m22, m23  output  d each  shared inversion inputs.
- t1_d, t2_d, t3_d, t4_d, t6_d, t8_d, t9_d, t10_d, t13_d, t15_d, t16_d, t17_d, t19_d, t20_d, t22_d, t23_d, t27_d, y5_d  output  d each  aligned pass-throughs.

## Operation
- Products, one MSKand_hpc2 each:
  - M1=t13·t6, M2=t23·t8, M4=t19·y5
  - M6=t3·t16, M7=t22·t9, M9=t20·t17
  - M11=t1·t15, M12=t4·t27, M14=t2·t10
- Share-wise XOR network after the gadgets:
  - M3=t14⊕M1, M5=M4⊕M1, M8=t26⊕M6, M10=M9⊕M6, M13=M12⊕M11, M15=M14⊕M11
  - M16=M3⊕M2, M17=M5⊕t24, M18=M8⊕M7, M19=M10⊕M15
  - m20=M16⊕M13, m21=M17⊕M15, m22=M18⊕M13, m23=M19⊕t25
- t14, t24, t25 and t26 enter the XOR network only after passing through a 1-cycle register, so they align with the gadget outputs.
- Pass-through registers:
  - The 18 forwarded values and the four aligned linear inputs load only when in_valid=1.
  - When in_valid=0 they hold, so no share toggles on idle cycles.
- Randomness and gadget stimulus:
  - rnd is sampled only on cycles with in_valid=1.
  - When in_valid=0 the bench drives rnd freely; the gadget outputs are then don't-care and are masked by out_valid.
- Valid pipeline:
  - A 1-bit shift register, reset to 0, tracks in_valid.
  - All data outputs are AND-gated to all-zero shares while out_valid=0.
- No backpressure: the stage accepts a new sharing every cycle.

## Timing
- Latency 1 cycle: in_valid high at edge n gives out_valid high in cycle n+1 with the matching results.
- Throughput: one sharing per cycle; back-to-back valids produce back-to-back outputs.
- in_valid low in cycle n gives out_valid low in cycle n+1, and all data outputs read 0.
- Reset values: out_valid=0; every m and *_d output is 0 on all shares.
- Reset asserted mid-operation:
  - out_valid drops to 0 immediately (asynchronous).
  - Data outputs go to 0 immediately via the out_valid gate.
  - An in-flight sharing is discarded.
- First in_valid after reset release: output appears one cycle later; no extra warm-up.
- Simultaneous in_valid=1 and rst_n=0: reset wins; nothing is captured.

## Configuration
- BP_C_MUL1_OUTREG_EN:
  - Defined: an extra register stage follows the XOR network and pass-throughs. Latency becomes 2 cycles, valid shift register is 2 deep, throughput is unchanged, and the extra stage is reset to 0 and loads only when its stage-valid is 1.
  - Undefined: latency is 1 cycle as described above.

## Test plan
- Reset, then hold rst_n=0 for 3 cycles → out_valid=0 and all outputs are 0 throughout.
- d=2, all inputs unshared 0 (random masks), in_valid pulse → next cycle out_valid=1 and m20..m23 recombine to 0,0,0,0.
- All 22 inputs unshared 1 → recombined m20..m23 = 1,1,1,1; every *_d output recombines to 1.
- Only t13=t6=1 → m20..m23 = 1,1,0,0. Only t19=y5=1 → m20..m23 = 0,1,0,0.
- 100 back-to-back random sharings with random rnd → out_valid high for 100 consecutive cycles; every result matches the golden model computed on recombined values.
- rst_n pulsed low while a valid is in flight → out_valid=0 immediately, the result is never emitted, and the next in_valid after release behaves normally.
